// File: rtl/vc_arbiter_demux_pkg.sv
// Shared definitions for the VC arbiter/demux: FSM state encoding and credit width.
package vc_arbiter_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ERROR = 2'd2
  } arb_state_t;

  localparam int CREDIT_W = 3;

endpackage

// File: rtl/vc_arbiter_demux_wrr_grant.sv
// Weighted round-robin grant between two requesters, with a saturating VC0 credit count.
module wrr_grant
  import vc_arbiter_demux_pkg::*;
#(
  parameter int WEIGHT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic elig0,
  input  logic elig1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [CREDIT_W-1:0] WEIGHT_C = WEIGHT[CREDIT_W-1:0];

  logic [CREDIT_W-1:0] credit;

  function automatic logic [CREDIT_W-1:0] sat_inc(input logic [CREDIT_W-1:0] val);
    return (val >= WEIGHT_C) ? WEIGHT_C : val + {{(CREDIT_W-1){1'b0}}, 1'b1};
  endfunction

  // VC0 keeps the grant until it has used its weight, unless VC1 has nothing to send
  assign gnt0 = elig0 && ((credit < WEIGHT_C) || !elig1);
  assign gnt1 = elig1 && !gnt0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '0;
    end else if (gnt0) begin
      credit <= sat_inc(credit);
    end else if (gnt1) begin
      credit <= '0;
    end
  end

endmodule

// File: rtl/vc_arbiter_demux.sv
// Arbitrates VC0/VC1 FIFO pops and routes each popped word to D0 or D1 by its destination bit.
module vc_arbiter_demux
  import vc_arbiter_demux_pkg::*;
#(
  parameter int DATA_SIZE  = 6,
  parameter int DEST_BIT   = 4,
  parameter int WEIGHT_VC0 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic [DATA_SIZE-1:0] data_vc0,
  input  logic [DATA_SIZE-1:0] data_vc1,
  input  logic                 fifo_pause_d0,
  input  logic                 fifo_pause_d1,
  input  logic                 fifo_error_any,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic                 arb_error,
  output logic                 arb_idle
);

  arb_state_t state, state_nxt;

  logic                 arb_go;
  logic                 elig0, elig1;
  logic                 gnt0, gnt1;
  logic                 vld_p1;
  logic                 src_p1;
  logic [DATA_SIZE-1:0] word_p1;
  logic                 dest_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Errors win over enable in every state; ERROR is left only through reset
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_error_any) state_nxt = ERROR;
               else if (enable)    state_nxt = ARB;
      ARB:     if (fifo_error_any) state_nxt = ERROR;
               else if (!enable)   state_nxt = IDLE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  // Both pauses gate eligibility: the destination is unknown until the word is popped
  assign arb_go = (state == ARB) && enable && !fifo_error_any;
  assign elig0  = arb_go && !fifo_empty_vc0 && !fifo_pause_d0 && !fifo_pause_d1;
  assign elig1  = arb_go && !fifo_empty_vc1 && !fifo_pause_d0 && !fifo_pause_d1;

  wrr_grant #(
    .WEIGHT (WEIGHT_VC0)
  ) u_grant (
    .clk   (clk),
    .reset (reset),
    .elig0 (elig0),
    .elig1 (elig1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign pop_vc0 = gnt0;
  assign pop_vc1 = gnt1;

  // Stage p1: remember which VC was popped; its registered data arrives next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      src_p1 <= 1'b0;
    end else begin
      vld_p1 <= gnt0 || gnt1;
      src_p1 <= gnt1;
    end
  end

  assign word_p1 = src_p1 ? data_vc1 : data_vc0;
  assign dest_p1 = word_p1[DEST_BIT];

  // Stage p2: push strobe and data into the selected destination FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_d0 <= 1'b0;
      push_d1 <= 1'b0;
      data_d0 <= '0;
      data_d1 <= '0;
    end else begin
      push_d0 <= vld_p1 && !dest_p1;
      push_d1 <= vld_p1 && dest_p1;
      if (vld_p1 && !dest_p1) data_d0 <= word_p1;
      if (vld_p1 && dest_p1)  data_d1 <= word_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) arb_error <= 1'b0;
    else       arb_error <= arb_error || (state_nxt == ERROR);
  end

  assign arb_idle = (state == IDLE) && !vld_p1 && !push_d0 && !push_d1;

endmodule

// File: doc/vc_arbiter_demux.md
Name: vc_arbiter_demux

Overview:
- Weighted round-robin arbiter between the two virtual-channel FIFOs (VC0, VC1).
- Pops at most one word per cycle and routes it by a destination bit to the D0 or D1 FIFO push interface.
- Honours the D0/D1 pause (almost-full) flags and halts on any FIFO error.
- Sits between the VC FIFO stage and the D0/D1 FIFO stage of the transaction datapath.

Parameters:
- DATA_SIZE, 6, width of every data word.
- DEST_BIT, 4, bit of the popped word that selects the destination: 0 = D0, 1 = D1.
- WEIGHT_VC0, 2, consecutive VC0 grants allowed before VC1 must be served when both are eligible (1..7).

Ports:
- clk, input, 1, the single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, 1, arbitration enable from the top-level controller.
- fifo_empty_vc0, input, 1, VC0 FIFO empty.
- fifo_empty_vc1, input, 1, VC1 FIFO empty.
- data_vc0, input, DATA_SIZE, VC0 registered pop data; valid the cycle after pop.
- data_vc1, input, DATA_SIZE, VC1 registered pop data; valid the cycle after pop.
- fifo_pause_d0, input, 1, D0 almost-full.
- fifo_pause_d1, input, 1, D1 almost-full.
- fifo_error_any, input, 1, OR of all FIFO error flags.
- pop_vc0, output, 1, pop strobe to VC0 (combinational).
- pop_vc1, output, 1, pop strobe to VC1 (combinational).
- push_d0, output, 1, push strobe to D0 (registered).
- push_d1, output, 1, push strobe to D1 (registered).
- data_d0, output, DATA_SIZE, data to D0 (registered).
- data_d1, output, DATA_SIZE, data to D1 (registered).
- arb_error, output, 1, sticky error indication (registered).
- arb_idle, output, 1, state IDLE and pipeline empty (combinational).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE, credit=0, s1_valid=0, s1_src=0, push_d0/push_d1=0, data_d0/data_d1=0, arb_error=0. While reset is high, pop_vc0/pop_vc1=0.
- FSM states:
  - IDLE: no pops. Go to ERROR if fifo_error_any, else to ARB if enable.
  - ARB: arbitrate every cycle. Go to ERROR if fifo_error_any, else to IDLE if !enable.
  - ERROR: pops permanently gated, arb_error=1. Left only by reset.
- fifo_error_any has priority over enable in every state.
- Eligibility (ARB only, enable=1, fifo_error_any=0): eligN = !fifo_empty_vcN && !fifo_pause_d0 && !fifo_pause_d1. Both pauses are checked because the destination is unknown before the pop.
- Grant rules, at most one pop per cycle:
  - elig0 && (credit<WEIGHT_VC0 || !elig1): pop_vc0=1; credit=min(credit+1, WEIGHT_VC0).
  - else if elig1: pop_vc1=1; credit=0.
  - else: no pop; credit held.
- credit is 3 bits wide and saturates at WEIGHT_VC0.
- Pipeline:
  - Pop in cycle N: s1_valid<=1 and s1_src<=granted VC at edge N.
  - Cycle N+1: word = s1_src ? data_vc1 : data_vc0. At edge N+1, push_dX<=1 and data_dX<=word, where X = word[DEST_BIT].
  - The other push is 0; its data register holds its previous value.
  - Pop-to-push latency is 2 cycles; throughput is 1 word per cycle.
- Back-to-back pops alternate or repeat VCs without bubbles; the pipeline registers reload every cycle.
- Pause margin: up to 2 words are in flight after a pause asserts. The downstream almost-full threshold must leave at least 2 free entries. The arbiter does not recheck pause for words already popped.
- Entering IDLE or ERROR does not flush in-flight words; they complete their push normally.
- arb_idle=1 only when state=IDLE && !s1_valid && !push_d0 && !push_d1.
- Reset asserted mid-operation: in-flight words are discarded and every register returns to its reset value immediately (asynchronous).

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ARB=2'd1, ERROR=2'd2) and the credit width constant (3).
- Sub-module wrr_grant: combinational grant logic plus the saturating credit register. Inputs elig0, elig1; outputs gnt0, gnt1.
- The FSM and the routing pipeline stay in the top module.

Test Plan:
- Reset, enable=1, VC0 holds 0x15 (bit4=1), VC1 empty -> pop_vc0 in cycle 1; push_d1=1 with data_d1=0x15 two cycles later; push_d0 stays 0.
- Both VCs non-empty continuously, WEIGHT_VC0=2 -> pop sequence VC0,VC0,VC1,VC0,VC0,VC1; exactly one pop per cycle, no bubbles.
- fifo_pause_d0=1 while VC1 is non-empty -> no pops during the pause. An already-popped word still pushes. Pops resume the cycle after pause drops.
- Word 0x05 (bit4=0) from VC1 -> push_d0=1, data_d0=0x05; data_d1 unchanged.
- fifo_error_any pulsed for 1 cycle during streaming -> arb_error=1 from the next edge; pops stop; in-flight words pushed; state stays ERROR until reset.
- Reset asserted between a pop and its push -> push_d0/push_d1 forced to 0 asynchronously; arb_idle=1 after reset deasserts with enable=0.
